// File: rtl/llc_output_encoder_if.sv
// LLC encoder bus: process-stage push port plus four
// outbound valid/ready channels (rsp, fwd, mem_req, dma_rsp).
interface llc_output_encoder_if #(
  parameter int LINE_ADDR_W = 28,
  parameter int DATA_W      = 128,
  parameter int MSG_W       = 3
);
  logic                     enc_valid;
  logic [1:0]               enc_chan;
  logic [MSG_W-1:0]         enc_msg;
  logic [LINE_ADDR_W-1:0]   enc_addr;
  logic [DATA_W-1:0]        enc_data;
  logic                     enc_ready;
  logic [3:0]               out_valid;
  logic [3:0]               out_ready;
  logic [4*MSG_W-1:0]       out_msg;
  logic [4*LINE_ADDR_W-1:0] out_addr;
  logic [4*DATA_W-1:0]      out_data;
  logic [3:0]               chan_full;
  logic                     idle;

  modport master (
    output enc_valid, enc_chan, enc_msg,
    output enc_addr, enc_data, out_ready,
    input  enc_ready, out_valid, out_msg,
    input  out_addr, out_data, chan_full, idle
  );

  modport slave (
    input  enc_valid, enc_chan, enc_msg,
    input  enc_addr, enc_data, out_ready,
    output enc_ready, out_valid, out_msg,
    output out_addr, out_data, chan_full, idle
  );
endinterface

// File: rtl/llc_output_encoder.sv
// LLC output encoder: one push per cycle into four per-channel
// circular FIFOs, each drained by its own valid/ready channel.
module llc_output_encoder #(
  parameter int LINE_ADDR_W = 28,
  parameter int DATA_W      = 128,
  parameter int MSG_W       = 3,
  parameter int DEPTH       = 2
) (
  input logic clk,
  input logic rst,
  llc_output_encoder_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]               valid;
  logic [3:0]               full;
  logic [4*MSG_W-1:0]       msg_o;
  logic [4*LINE_ADDR_W-1:0] addr_o;
  logic [4*DATA_W-1:0]      data_o;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic [CW-1:0]          count;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic                   push;
    logic                   pop;
    logic [MSG_W-1:0]       msg_q  [DEPTH];
    logic [LINE_ADDR_W-1:0] addr_q [DEPTH];

    // full is the registered count, so a pop never frees a slot early
    assign push = bus.enc_valid
                & (bus.enc_chan == 2'(i))
                & ~full[i];
    assign pop  = valid[i] & bus.out_ready[i];

    assign valid[i] = (count != '0);
    assign full[i]  = (count == CW'(DEPTH));

    always_ff @(posedge clk) begin
      if (rst) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)
          count <= count + 1'b1;
        else if (!push && pop)
          count <= count - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        msg_q[wr_ptr]  <= bus.enc_msg;
        addr_q[wr_ptr] <= bus.enc_addr;
      end
    end

    assign msg_o[i*MSG_W +: MSG_W] =
      valid[i] ? msg_q[rd_ptr] : '0;
    assign addr_o[i*LINE_ADDR_W +: LINE_ADDR_W] =
      valid[i] ? addr_q[rd_ptr] : '0;

    if (i == 1) begin : g_nodata
      assign data_o[i*DATA_W +: DATA_W] = '0;
    end else begin : g_data
      logic [DATA_W-1:0] data_q [DEPTH];

      always_ff @(posedge clk) begin
        if (push) data_q[wr_ptr] <= bus.enc_data;
      end

      assign data_o[i*DATA_W +: DATA_W] =
        valid[i] ? data_q[rd_ptr] : '0;
    end
  end

  assign bus.enc_ready = ~full[bus.enc_chan];
  assign bus.out_valid = valid;
  assign bus.chan_full = full;
  assign bus.out_msg   = msg_o;
  assign bus.out_addr  = addr_o;
  assign bus.out_data  = data_o;
  assign bus.idle      = ~(|valid) & ~bus.enc_valid;
endmodule

// File: tb/tb_llc_output_encoder.sv
// Randomized + directed bench for llc_output_encoder against a
// queue-based reference model of the four channel FIFOs.
module tb_llc_output_encoder;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 3;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [MW-1:0] msg;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  bit   run = 1'b0;

  ent_t q [4][$];
  logic [AW-1:0] pops3 [$];

  llc_output_encoder_if #(
    .LINE_ADDR_W(AW), .DATA_W(DW), .MSG_W(MW)
  ) bus ();

  llc_output_encoder #(
    .LINE_ADDR_W(AW), .DATA_W(DW),
    .MSG_W(MW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: queue per channel, full judged on pre-edge size
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) q[i].delete();
    end else begin
      ent_t e;
      int   c;
      bit   can_push;
      c = int'(bus.enc_chan);
      can_push = bus.enc_valid && (q[c].size() < DEPTH);
      for (int i = 0; i < 4; i++)
        if (q[i].size() != 0 && bus.out_ready[i])
          void'(q[i].pop_front());
      if (can_push) begin
        e.msg  = bus.enc_msg;
        e.addr = bus.enc_addr;
        e.data = (c == 1) ? '0 : bus.enc_data;
        q[c].push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      logic [3:0] ev;
      logic [3:0] ef;
      bit         anyq;
      anyq = 1'b0;
      for (int i = 0; i < 4; i++) begin
        ent_t e;
        ev[i] = (q[i].size() != 0);
        ef[i] = (q[i].size() == DEPTH);
        e = ev[i] ? q[i][0] : '0;
        anyq |= ev[i];
        chk($sformatf("msg%0d", i),
            DW'(bus.out_msg[i*MW +: MW]), DW'(e.msg));
        chk($sformatf("addr%0d", i),
            DW'(bus.out_addr[i*AW +: AW]), DW'(e.addr));
        chk($sformatf("data%0d", i),
            bus.out_data[i*DW +: DW], e.data);
        if (i == 3 && ev[3] && bus.out_ready[3])
          pops3.push_back(bus.out_addr[3*AW +: AW]);
      end
      chk("out_valid", DW'(bus.out_valid), DW'(ev));
      chk("chan_full", DW'(bus.chan_full), DW'(ef));
      chk("idle", DW'(bus.idle),
          DW'(!anyq && !bus.enc_valid));
      if (bus.enc_valid)
        chk("enc_ready", DW'(bus.enc_ready),
            DW'(!ef[bus.enc_chan]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] c,
                      input logic [MW-1:0] m,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    bus.enc_valid = 1'b1;
    bus.enc_chan  = c;
    bus.enc_msg   = m;
    bus.enc_addr  = a;
    bus.enc_data  = d;
    cyc();
    bus.enc_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.enc_valid = 1'b0;
    bus.enc_chan  = '0;
    bus.enc_msg   = '0;
    bus.enc_addr  = '0;
    bus.enc_data  = '0;
    bus.out_ready = '0;
    cyc();
    run = 1'b1;
    bus.enc_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.enc_chan = 2'(c);
      #1;
      chk("rst_enc_ready", DW'(bus.enc_ready), DW'(1));
    end
    cyc();
    bus.enc_valid = 1'b0;
    rst = 1'b0;
    chk("rst_valid", DW'(bus.out_valid), '0);
    chk("rst_data", bus.out_data[DW-1:0], '0);

    push(2'd0, 3'b010, 28'h00ABCDE, 128'h1);
    chk("t1_valid", DW'(bus.out_valid), DW'(4'b0001));
    chk("t1_addr", DW'(bus.out_addr[AW-1:0]), DW'(28'h00ABCDE));
    chk("t1_msg", DW'(bus.out_msg[MW-1:0]), DW'(3'b010));
    chk("t1_data", bus.out_data[DW-1:0], 128'h1);
    bus.out_ready = 4'b0001;
    cyc();
    bus.out_ready = '0;
    chk("t1_empty", DW'(bus.out_valid), '0);
    chk("t1_idle", DW'(bus.idle), DW'(1));

    push(2'd2, 3'd1, 28'h10, 128'hA);
    push(2'd2, 3'd1, 28'h20, 128'hB);
    chk("t2_full", DW'(bus.chan_full[2]), DW'(1));
    bus.enc_valid = 1'b1;
    bus.enc_chan  = 2'd2;
    bus.enc_addr  = 28'h30;
    #1;
    chk("t2_ready", DW'(bus.enc_ready), DW'(0));
    cyc();
    bus.enc_valid = 1'b0;
    chk("t2_still_full", DW'(bus.chan_full[2]), DW'(1));
    bus.out_ready = 4'b0100;
    chk("t2_pop0", DW'(bus.out_addr[2*AW +: AW]), DW'(28'h10));
    cyc();
    chk("t2_pop1", DW'(bus.out_addr[2*AW +: AW]), DW'(28'h20));
    cyc();
    bus.out_ready = '0;
    chk("t2_empty", DW'(bus.out_valid[2]), DW'(0));

    push(2'd1, 3'd4, 28'h41, 128'hFF);
    push(2'd1, 3'd5, 28'h42, 128'hFF);
    bus.out_ready = 4'b0010;
    bus.enc_valid = 1'b1;
    bus.enc_chan  = 2'd1;
    bus.enc_addr  = 28'h43;
    #1;
    chk("t3_refuse", DW'(bus.enc_ready), DW'(0));
    cyc();
    bus.enc_valid = 1'b0;
    bus.out_ready = '0;
    chk("t3_notfull", DW'(bus.chan_full[1]), DW'(0));
    chk("t3_head", DW'(bus.out_addr[AW +: AW]), DW'(28'h42));
    bus.out_ready = 4'b0010;
    cyc();
    bus.out_ready = '0;

    pops3.delete();
    begin
      int sent = 0;
      int n = 0;
      while ((sent < 7 || bus.out_valid[3]) && n < 100) begin
        bit acc;
        bus.out_ready[3] = n[0];
        bus.enc_valid = (sent < 7);
        bus.enc_chan  = 2'd3;
        bus.enc_addr  = AW'(28'h100 + sent);
        bus.enc_data  = {4{$urandom}};
        #1;
        acc = bus.enc_valid && bus.enc_ready;
        cyc();
        if (acc) sent++;
        n++;
      end
      bus.enc_valid = 1'b0;
      bus.out_ready = '0;
      chk("t4_count", DW'(pops3.size()), DW'(7));
      for (int k = 0; k < 7 && k < pops3.size(); k++)
        chk("t4_order", DW'(pops3[k]), DW'(28'h100 + k));
    end

    for (int c = 0; c < 4; c++)
      push(2'(c), 3'(c), AW'(c + 1), 128'h5);
    chk("t5_all", DW'(bus.out_valid), DW'(4'hF));
    chk("t5_fwd0", bus.out_data[DW +: DW], '0);
    bus.out_ready = 4'hF;
    cyc();
    bus.out_ready = '0;
    chk("t5_none", DW'(bus.out_valid), '0);

    push(2'd0, 3'd1, 28'h1, 128'h1);
    push(2'd0, 3'd1, 28'h2, 128'h2);
    push(2'd2, 3'd1, 28'h3, 128'h3);
    push(2'd2, 3'd1, 28'h4, 128'h4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_valid", DW'(bus.out_valid), '0);
    chk("t6_full", DW'(bus.chan_full), '0);
    chk("t6_data", bus.out_data[DW-1:0] | bus.out_data[2*DW +: DW], '0);
    chk("t6_addr", DW'(bus.out_addr), '0);
    push(2'd0, 3'd6, 28'h55, 128'h9);
    chk("t6_sole", DW'(bus.out_valid), DW'(4'b0001));
    chk("t6_addr0", DW'(bus.out_addr[AW-1:0]), DW'(28'h55));
    bus.out_ready = 4'b0001;
    cyc();
    bus.out_ready = '0;

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.enc_valid = $urandom_range(0, 3) != 0;
      bus.enc_chan  = 2'($urandom);
      bus.enc_msg   = 3'($urandom);
      bus.enc_addr  = 28'($urandom);
      bus.enc_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = 4'($urandom);
      cyc();
    end
    rst = 1'b0;
    bus.enc_valid = 1'b0;
    bus.out_ready = 4'hF;
    begin
      int n = 0;
      while (!bus.idle && n < 10) begin
        cyc();
        n++;
      end
      chk("drain_idle", DW'(bus.idle), DW'(1));
    end
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
